// File: rtl/uart_frame_receiver_pkg.sv
// Shared definitions for the 34-byte capture-frame UART link.
// Used by both the receiver and the transmitter side of the link.
package uart_frame_receiver_pkg;

  // Line format
  localparam int CLKS_PER_BIT_DEF = 10;  // i_Clk cycles per UART bit
  localparam int STOP_BITS        = 2;
  localparam int TIMEOUT_BITS_DEF = 22;  // idle bit-times tolerated between bytes

  // Frame layout: byte 0 is the MSB byte of ADC channel 1
  localparam int FRAME_NUM_BYTES  = 34;
  localparam int FRAME_W          = FRAME_NUM_BYTES * 8;
  localparam int ADC1_MSB         = 271;
  localparam int ADC1_LSB         = 144;
  localparam int ADC2_MSB         = 143;
  localparam int ADC2_LSB         = 16;
  localparam int ENC_MSB          = 15;
  localparam int ENC_LSB          = 0;

  // Receiver FSM encodings (visible on o_Debug_State)
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_BIT = 3'd1,
    ST_DATA_BITS = 3'd2,
    ST_STOP_BIT1 = 3'd3,
    ST_STOP_BIT2 = 3'd4,
    ST_STORE     = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } rx_state_e;

  // Bit position of the MSB of byte 'idx' inside a frame of 'frame_w' bits
  function automatic int byte_msb(input int frame_w, input int idx);
    return frame_w - 1 - idx * 8;
  endfunction

endpackage

// File: rtl/uart_frame_receiver_byte_rx.sv
// Byte-level UART receiver: input synchroniser plus start/data/stop bit FSM.
// Emits one byte_valid pulse (STORE state) per clean byte and a stop_error
// pulse when either stop bit samples low; after an error it waits for the
// line to return high for a full bit time so a break cannot fake a start.
module uart_byte_rx
  import uart_frame_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Byte,
  output logic       o_Byte_Valid,
  output logic       o_Stop_Error,
  output rx_state_e  o_State
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  logic        rx_meta;
  logic        rx_sync;
  rx_state_e   state;
  rx_state_e   next_state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        half_tick;
  logic        bit_tick;

  assign half_tick = (bit_cnt == HALF_LAST);
  assign bit_tick  = (bit_cnt == BIT_LAST);

  // Two-flop synchroniser for the asynchronous line; idles high out of reset
  always_ff @(posedge i_Clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Next-state logic. IDLE is only ever entered with the line high (reset,
  // good stop bit, WAIT_IDLE, or a glitch that read high at mid-bit), so a
  // low level seen in IDLE is the 1->0 start edge. Testing the level rather
  // than an edge also catches a start that began during the STORE cycle.
  always_comb begin
    // NOTE: default first so every path assigns next_state; otherwise an
    // unassigned path infers a latch.
    next_state = state;
    unique case (state)
      ST_IDLE:      if (!rx_sync) next_state = ST_START_BIT;
      ST_START_BIT: if (half_tick) next_state = rx_sync ? ST_IDLE : ST_DATA_BITS;
      ST_DATA_BITS: if (bit_tick && bit_idx == 3'd7) next_state = ST_STOP_BIT1;
      ST_STOP_BIT1: if (bit_tick) next_state = rx_sync ? ST_STOP_BIT2 : ST_WAIT_IDLE;
      ST_STOP_BIT2: if (bit_tick) next_state = rx_sync ? ST_STORE : ST_WAIT_IDLE;
      ST_STORE:     next_state = ST_IDLE;
      ST_WAIT_IDLE: if (rx_sync && bit_tick) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Bit-clock counter, data bit index and LSB-first shift register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      unique case (state)
        ST_START_BIT: bit_cnt <= half_tick ? '0 : bit_cnt + 16'd1;
        ST_DATA_BITS: begin
          if (bit_tick) begin
            bit_cnt   <= '0;
            bit_idx   <= bit_idx + 3'd1;
            shift_reg <= {rx_sync, shift_reg[7:1]};
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        ST_STOP_BIT1,
        ST_STOP_BIT2: bit_cnt <= bit_tick ? '0 : bit_cnt + 16'd1;
        // Counts consecutive high cycles; any low sample restarts the run
        ST_WAIT_IDLE: bit_cnt <= (!rx_sync || bit_tick) ? '0 : bit_cnt + 16'd1;
        default: begin
          bit_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    o_Byte       = shift_reg;
    o_State      = state;
    o_Byte_Valid = (state == ST_STORE);
    o_Stop_Error = 1'b0;
    if ((state == ST_STOP_BIT1 || state == ST_STOP_BIT2) && bit_tick && !rx_sync)
      o_Stop_Error = 1'b1;
  end

endmodule

// File: rtl/uart_frame_receiver.sv
// Receive end of the 34-byte capture-frame UART link. Reassembles bytes into
// a frame, drops partial frames on stop-bit error or inter-byte timeout, and
// presents the last good frame with a one-cycle valid pulse.
module uart_frame_receiver
  import uart_frame_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FRAME_BYTES  = FRAME_NUM_BYTES,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Rx_Serial,
  output logic [FRAME_BYTES*8-1:0] o_Frame,
  output logic [127:0]             o_ADC_Data1,
  output logic [127:0]             o_ADC_Data2,
  output logic [15:0]              o_Encoder,
  output logic                     o_Frame_Valid,
  output logic                     o_Frame_Error,
  output logic [5:0]               o_Byte_Count,
  output logic [2:0]               o_Debug_State
);

  localparam int          FW           = FRAME_BYTES * 8;
  localparam int          TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int          TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CLKS - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CLKS);
  localparam logic [5:0]  IDX_LAST     = 6'(FRAME_BYTES - 1);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          stop_error;
  rx_state_e     rx_state;
  logic [FW-1:0] frame_buf;
  logic [5:0]    byte_idx;
  logic [TW-1:0] idle_cnt;
  logic          idle_partial;
  logic          timeout_hit;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Rx_Serial  (i_Rx_Serial),
    .o_Byte       (rx_byte),
    .o_Byte_Valid (byte_valid),
    .o_Stop_Error (stop_error),
    .o_State      (rx_state)
  );

  // A partial frame is waiting whenever the byte FSM is idle mid-frame
  assign idle_partial = (rx_state == ST_IDLE) && (byte_idx != 6'd0);
  assign timeout_hit  = idle_partial && (idle_cnt == TO_LAST);

  // Inter-byte idle counter, saturating, cleared whenever a byte is in flight
  always_ff @(posedge i_Clk) begin
    if (i_Reset || !idle_partial) idle_cnt <= '0;
    else if (idle_cnt != TO_MAX)  idle_cnt <= idle_cnt + TW'(1);
  end

  // Assembly buffer: each stored byte lands at its frame position
  always_ff @(posedge i_Clk) begin
    // NOTE: no reset on this wide buffer; a frame is only published after all
    // earlier bytes were rewritten since the index last returned to zero.
    if (byte_valid)
      frame_buf[byte_msb(FW, int'(byte_idx)) -: 8] <= rx_byte;
  end

  // Byte index, published frame and status pulses
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      byte_idx      <= '0;
      o_Frame       <= '0;
      o_Frame_Valid <= 1'b0;
      o_Frame_Error <= 1'b0;
    end else begin
      o_Frame_Valid <= 1'b0;
      o_Frame_Error <= 1'b0;
      if (byte_valid) begin
        if (byte_idx == IDX_LAST) begin
          // Last byte comes straight from the byte receiver so the whole
          // frame updates in the same edge as the valid pulse
          o_Frame       <= {frame_buf[FW-1:8], rx_byte};
          o_Frame_Valid <= 1'b1;
          byte_idx      <= '0;
        end else begin
          byte_idx <= byte_idx + 6'd1;
        end
      end else if (stop_error || timeout_hit) begin
        o_Frame_Error <= 1'b1;
        byte_idx      <= '0;
      end
    end
  end

  // Field views of the published frame
  always_comb begin
    o_ADC_Data1   = o_Frame[ADC1_MSB:ADC1_LSB];
    o_ADC_Data2   = o_Frame[ADC2_MSB:ADC2_LSB];
    o_Encoder     = o_Frame[ENC_MSB:ENC_LSB];
    o_Byte_Count  = byte_idx;
    o_Debug_State = rx_state;
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver at 10 clocks per bit.
module tb_uart_frame_receiver;

  localparam int CPB = 10;
  localparam int NB  = 34;

  logic         i_Clk = 1'b0;
  logic         i_Reset = 1'b1;
  logic         i_Rx_Serial = 1'b1;
  logic [271:0] o_Frame;
  logic [127:0] o_ADC_Data1;
  logic [127:0] o_ADC_Data2;
  logic [15:0]  o_Encoder;
  logic         o_Frame_Valid;
  logic         o_Frame_Error;
  logic [5:0]   o_Byte_Count;
  logic [2:0]   o_Debug_State;

  uart_frame_receiver #(
    .CLKS_PER_BIT (CPB),
    .FRAME_BYTES  (NB),
    .TIMEOUT_BITS (22)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_Rx_Serial   (i_Rx_Serial),
    .o_Frame       (o_Frame),
    .o_ADC_Data1   (o_ADC_Data1),
    .o_ADC_Data2   (o_ADC_Data2),
    .o_Encoder     (o_Encoder),
    .o_Frame_Valid (o_Frame_Valid),
    .o_Frame_Error (o_Frame_Error),
    .o_Byte_Count  (o_Byte_Count),
    .o_Debug_State (o_Debug_State)
  );

  always #5 i_Clk = ~i_Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_err_cyc = 0;
  int valid_cyc[$];
  logic [271:0] cap_frames[$];

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  always @(negedge i_Clk) begin
    if (o_Frame_Valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc.push_back(cyc);
      cap_frames.push_back(o_Frame);
    end
    if (o_Frame_Error) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
    end
    if (o_Frame_Valid && o_Frame_Error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    i_Rx_Serial = v;
    repeat (CPB) @(negedge i_Clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop2);
    bit_time(1'b0);
    for (int k = 0; k < 8; k++) bit_time(b[k]);
    bit_time(1'b1);
    bit_time(!bad_stop2);
    i_Rx_Serial = 1'b1;
  endtask

  function automatic logic [7:0] byte_of(input int pat, input int i);
    case (pat)
      0:       return 8'(i);
      1:       return 8'(255 - i);
      2:       return 8'(i * 37 + 11);
      default: return 8'(i * 13 + pat * 29);
    endcase
  endfunction

  function automatic logic [271:0] frame_of(input int pat);
    logic [271:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f[271 - 8 * i -: 8] = byte_of(pat, i);
    return f;
  endfunction

  task automatic send_bytes(input int pat, input int first, input int count);
    for (int i = first; i < first + count; i++) send_byte(byte_of(pat, i), 1'b0);
  endtask

  task automatic idle(input int n);
    i_Rx_Serial = 1'b1;
    repeat (n) @(negedge i_Clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, t_end, lat;
    logic [271:0] exp_f;

    // Reset state
    repeat (3) @(negedge i_Clk);
    check("rst_frame", o_Frame, '0);
    check("rst_count", o_Byte_Count, 0);
    check("rst_valid", o_Frame_Valid, 0);
    check("rst_error", o_Frame_Error, 0);
    check("rst_state", o_Debug_State, 0);
    i_Reset = 1'b0;
    idle(20);

    // 1: counting frame 0x00..0x21, byte count reaches 33 before the last byte
    send_bytes(0, 0, NB - 1);
    idle(5);
    check("t1_count_33", o_Byte_Count, 33);
    check("t1_no_valid_yet", valid_cnt, 0);
    send_bytes(0, NB - 1, 1);
    idle(20);
    check("t1_valid_pulses", valid_cnt, 1);
    check("t1_errors", err_cnt, 0);
    check("t1_adc1", o_ADC_Data1, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_adc2", o_ADC_Data2, 128'h101112131415161718191A1B1C1D1E1F);
    check("t1_enc", o_Encoder, 16'h2021);
    check("t1_count_0", o_Byte_Count, 0);
    if (cap_frames.size() > 0) check("t1_frame_at_pulse", cap_frames[0], frame_of(0));

    // 2: three-clock low glitch is not a start bit
    i_Rx_Serial = 1'b0;
    repeat (3) @(negedge i_Clk);
    idle(30);
    check("t2_count", o_Byte_Count, 0);
    check("t2_errors", err_cnt, 0);
    check("t2_valids", valid_cnt, 1);
    check("t2_state_idle", o_Debug_State, 0);

    // 3: byte 5 with a bad second stop bit
    send_bytes(1, 0, 5);
    check("t3_count_5", o_Byte_Count, 5);
    send_byte(byte_of(1, 5), 1'b1);
    idle(30);
    check("t3_error_pulse", err_cnt, 1);
    check("t3_count_0", o_Byte_Count, 0);
    check("t3_frame_kept", o_Frame, frame_of(0));
    send_bytes(2, 0, NB);
    idle(20);
    check("t3_next_valid", valid_cnt, 2);
    check("t3_next_frame", o_Frame, frame_of(2));

    // 4: ten bytes then a long idle: timeout drops the partial frame
    send_bytes(3, 0, 10);
    t_end = cyc;
    e0 = err_cnt;
    check("t4_count_10", o_Byte_Count, 10);
    repeat (200) @(negedge i_Clk);
    check("t4_no_early_timeout", err_cnt, e0);
    for (int k = 0; k < 2220 && err_cnt == e0; k++) @(negedge i_Clk);
    check("t4_timeout_pulse", err_cnt, e0 + 1);
    lat = last_err_cyc - t_end;
    check("t4_timeout_latency_ok", (lat >= 213 && lat <= 223), 1);
    check("t4_count_0", o_Byte_Count, 0);
    check("t4_frame_kept", o_Frame, frame_of(2));
    idle(10);
    send_bytes(4, 0, NB);
    idle(20);
    check("t4_next_valid", valid_cnt, 3);
    check("t4_next_frame", o_Frame, frame_of(4));

    // 5: reset in the middle of byte 20
    send_bytes(5, 0, 20);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    check("t5_rst_frame", o_Frame, '0);
    check("t5_rst_enc", o_Encoder, 0);
    check("t5_rst_count", o_Byte_Count, 0);
    check("t5_rst_state", o_Debug_State, 0);
    i_Rx_Serial = 1'b1;
    @(negedge i_Clk);
    i_Reset = 1'b0;
    idle(20);
    send_bytes(6, 0, NB);
    idle(20);
    check("t5_after_valid", valid_cnt, 4);
    check("t5_after_frame", o_Frame, frame_of(6));

    // 6: two frames back to back with no gap
    v0 = valid_cnt;
    send_bytes(7, 0, NB);
    send_bytes(8, 0, NB);
    idle(20);
    check("t6_valid_pulses", valid_cnt, v0 + 2);
    if (valid_cyc.size() == v0 + 2) begin
      check("t6_spacing", valid_cyc[v0 + 1] - valid_cyc[v0], 3740);
      check("t6_frame_a", cap_frames[v0], frame_of(7));
      check("t6_frame_b", cap_frames[v0 + 1], frame_of(8));
    end
    exp_f = frame_of(8);
    check("t6_adc1_b", o_ADC_Data1, exp_f[271:144]);
    check("t6_adc2_b", o_ADC_Data2, exp_f[143:16]);
    check("t6_enc_b", o_Encoder, exp_f[15:0]);

    check("valid_error_overlap", both_cnt, 0);
    check("total_errors", err_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
